// File: rtl/bist_pkg.sv
// Shared types and default widths for the BIST response analyzer slice.
package bist_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } bist_state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] mask;
  } log_entry_t;

endpackage

// File: rtl/bist_resp_analyzer_if.sv
// Engine-to-analyzer stream: address, expected data, write enable, completion and memory read data.
interface bist_resp_analyzer_if
  import bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] exp_dat;
  logic              w_en_in;
  logic              op_done;
  logic [DATA_W-1:0] mem_dat;

  modport master (output addr_in, exp_dat, w_en_in, op_done, mem_dat);
  modport slave  (input  addr_in, exp_dat, w_en_in, op_done, mem_dat);

endinterface

// File: rtl/bist_fail_fifo.sv
// Synchronous fail-log FIFO with synchronous clear and a sticky overflow flag.
module bist_fail_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign ovf   = ovf_q;

  always_comb begin
    do_pop   = pop && !empty;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (push && !do_push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage has no reset; pointers define validity and pop_data is gated while empty.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/bist_resp_analyzer.sv
// BIST response analyzer: compares memory read data against the engine's expected stream.
// Define BIST_FAIL_LOG_EN to build the fail log; otherwise the log outputs are tied to 0.
module bist_resp_analyzer
  import bist_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int READ_LAT  = 1,
  parameter int CNT_W     = 8,
  parameter int LOG_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  bist_resp_analyzer_if.slave      eng,
  output logic                     done,
  output logic                     pass,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic [DATA_W-1:0]        fail_bits,
  output logic                     ff_valid,
  output logic [ADDR_W-1:0]        ff_addr,
  output logic [DATA_W-1:0]        ff_exp,
  output logic [DATA_W-1:0]        ff_act,
  input  logic                     log_rd,
  output logic                     log_valid,
  output logic [ADDR_W+DATA_W-1:0] log_data,
  output logic                     log_ovf
);

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp;
  } pipe_t;

  bist_state_e       state_q, state_d;
  logic [1:0]        drain_q, drain_d;
  pipe_t             pipe_q [READ_LAT];
  pipe_t             pipe_d [READ_LAT];
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [DATA_W-1:0] fail_bits_q, fail_bits_d;
  logic              ff_valid_q, ff_valid_d;
  logic [ADDR_W-1:0] ff_addr_q, ff_addr_d;
  logic [DATA_W-1:0] ff_exp_q, ff_exp_d;
  logic [DATA_W-1:0] ff_act_q, ff_act_d;

  logic              start, sample, cmp_active, mismatch;
  pipe_t             tail;
  logic [DATA_W-1:0] mask;

  assign start      = (state_q == IDLE) && en;
  assign sample     = (state_q == RUN) && en && !eng.w_en_in;
  assign cmp_active = ((state_q == RUN) || (state_q == DRAIN)) && en;
  assign tail       = pipe_q[READ_LAT-1];
  assign mask       = tail.exp ^ eng.mem_dat;
  assign mismatch   = cmp_active && tail.vld && (mask != '0);

  always_comb begin
    // NOTE: every _d starts from its held value so no branch can infer a latch.
    state_d     = state_q;
    drain_d     = drain_q;
    fail_cnt_d  = fail_cnt_q;
    fail_bits_d = fail_bits_q;
    ff_valid_d  = ff_valid_q;
    ff_addr_d   = ff_addr_q;
    ff_exp_d    = ff_exp_q;
    ff_act_d    = ff_act_q;

    case (state_q)
      IDLE:  if (en) state_d = RUN;
      RUN: begin
        if (!en) state_d = IDLE;
        else if (eng.op_done) begin
          state_d = DRAIN;
          drain_d = 2'(READ_LAT - 1);
        end
      end
      DRAIN: begin
        if (!en) state_d = IDLE;
        else if (drain_q == '0) state_d = DONE;
        else drain_d = drain_q - 2'd1;
      end
      DONE:    if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Entries shift one stage per cycle; write cycles and non-RUN cycles insert bubbles.
    pipe_d[0] = '{vld: sample, addr: eng.addr_in, exp: eng.exp_dat};
    for (int i = 1; i < READ_LAT; i++) pipe_d[i] = pipe_q[i-1];

    if (start) begin
      for (int i = 0; i < READ_LAT; i++) pipe_d[i] = '0;
      fail_cnt_d  = '0;
      fail_bits_d = '0;
      ff_valid_d  = 1'b0;
      ff_addr_d   = '0;
      ff_exp_d    = '0;
      ff_act_d    = '0;
    end else if (mismatch) begin
      if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
      fail_bits_d = fail_bits_q | mask;
      if (!ff_valid_q) begin
        ff_valid_d = 1'b1;
        ff_addr_d  = tail.addr;
        ff_exp_d   = tail.exp;
        ff_act_d   = eng.mem_dat;
      end
    end

    done_d = (state_d == DONE);
    pass_d = done_d && (fail_cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      drain_q     <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe_q[i] <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_cnt_q  <= '0;
      fail_bits_q <= '0;
      ff_valid_q  <= 1'b0;
      ff_addr_q   <= '0;
      ff_exp_q    <= '0;
      ff_act_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop update from the same pre-edge values.
      state_q     <= state_d;
      drain_q     <= drain_d;
      pipe_q      <= pipe_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_bits_q <= fail_bits_d;
      ff_valid_q  <= ff_valid_d;
      ff_addr_q   <= ff_addr_d;
      ff_exp_q    <= ff_exp_d;
      ff_act_q    <= ff_act_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_cnt  = fail_cnt_q;
  assign fail_bits = fail_bits_q;
  assign ff_valid  = ff_valid_q;
  assign ff_addr   = ff_addr_q;
  assign ff_exp    = ff_exp_q;
  assign ff_act    = ff_act_q;

`ifdef BIST_FAIL_LOG_EN
  logic log_empty;
  logic log_full_unused;

  bist_fail_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (LOG_DEPTH)
  ) u_fail_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start),
    .push      (mismatch),
    .push_data ({tail.addr, mask}),
    .pop       (log_rd),
    .pop_data  (log_data),
    .full      (log_full_unused),
    .empty     (log_empty),
    .ovf       (log_ovf)
  );

  assign log_valid = !log_empty;
`else
  localparam int log_depth_unused = LOG_DEPTH;
  logic log_rd_unused;

  assign log_rd_unused = log_rd;
  assign log_valid     = 1'b0;
  assign log_data      = '0;
  assign log_ovf       = 1'b0;
`endif

endmodule

// File: doc/bist_resp_analyzer.md
# bist_resp_analyzer

Memory-side response analyzer for the BIST engine. It observes the engine's address, data and write-enable stream together with the memory's read data, and compares every read against the expected value. It accumulates the fail count, first-fail details and a per-bit fail mask, then reports a pass/fail verdict when the engine signals op_done. It sits between the memory under test and the test controller, on the receiving end of the engine's memory interface.

## Interface
- ADDR_W, 8, address width; matches engine addr_out
- DATA_W, 4, data width; matches engine dat_out / memory data
- READ_LAT, 1, memory read latency in cycles; legal values 1 or 2
- CNT_W, 8, fail counter width
- LOG_DEPTH, 4, fail log entries; power of two; used only with BIST_FAIL_LOG_EN
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  analysis enable; high for the whole test run
- addr_in  in  ADDR_W  engine address (addr_out)
- exp_dat  in  DATA_W  engine data (dat_out); carries the expected value when w_en_in=0
- w_en_in  in  1  engine write enable; 0 marks a read cycle to be checked
- op_done  in  1  engine completion flag
- mem_dat  in  DATA_W  memory read data; valid READ_LAT cycles after the read address
- done  out  1  verdict valid
- pass  out  1  1 when done and fail_cnt==0
- fail_cnt  out  CNT_W  saturating mismatch count
- fail_bits  out  DATA_W  OR of all mismatch masks (exp XOR act)
- ff_valid  out  1  first-fail fields valid
- ff_addr  out  ADDR_W  address of the first mismatch
- ff_exp, ff_act  out  DATA_W each  expected and actual data at the first mismatch
- log_rd  in  1  pop one fail-log entry
- log_valid  out  1  fail log not empty
- log_data  out  ADDR_W+DATA_W  {addr, mismatch mask} at the log head
- log_ovf  out  1  sticky: a mismatch was dropped because the log was full

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on en=1. Entering RUN clears all results, the log, and log_ovf.
- RUN: every cycle with w_en_in=0 pushes {addr_in, exp_dat, 1} into a READ_LAT-deep pipeline. A write cycle pushes a bubble. A pipeline entry is compared with mem_dat when it reaches the output.
- Mismatch (mask = exp XOR mem_dat, nonzero):
  - fail_cnt increments, saturating at 2^CNT_W-1.
  - mask is ORed into fail_bits.
  - If ff_valid=0: ff_addr, ff_exp and ff_act are captured and ff_valid is set.
  - A log entry is pushed.
- RUN -> DRAIN on op_done=1. The op_done cycle itself still samples a read.
- DRAIN lasts exactly READ_LAT cycles so in-flight reads are compared. No new reads are sampled. Then -> DONE.
- DONE: done=1 and pass=(fail_cnt==0). All results hold. DONE -> IDLE when en=0.
- en=0 in RUN or DRAIN aborts to IDLE. done stays 0. Results hold until the next start.
- Fail counting is independent of the log: fail_cnt counts even when the log is full.

## Timing
- Reset value of every output is 0. Pipeline and log are empty after reset.
- Compare latency: a read presented at cycle t is compared at cycle t+READ_LAT. Results update at the edge ending that cycle.
- done asserts READ_LAT+1 cycles after the op_done cycle.
- Back-to-back reads are compared every cycle; throughput is 1 compare per cycle.
- Log handshake: the entry is consumed on a cycle with log_rd=1 and log_valid=1. log_rd while empty is ignored.
- Log push and pop in the same cycle: both take effect and the occupancy is unchanged.
- Push when full, with no pop in that cycle: the entry is dropped and log_ovf is set.
- Pointers wrap modulo LOG_DEPTH.
- rst_n low at any time immediately clears state, pipeline, results and log.

## Configuration
- BIST_FAIL_LOG_EN defined: the LOG_DEPTH fail log and its handshake are built.
- Undefined: no log storage is built. log_valid, log_data and log_ovf are tied to 0. log_rd is ignored. All other behaviour is identical.

## Structure
- Shared package bist_pkg holds:
  - the analyzer state enum (IDLE/RUN/DRAIN/DONE)
  - default widths ADDR_W=8, DATA_W=4
  - the log entry struct {addr, mask}
- One sub-module, bist_fail_fifo: a synchronous FIFO with push, pop, full, empty and overflow flag, instantiated only under BIST_FAIL_LOG_EN.

## Test plan
- Clean run, READ_LAT=1:
  - Stimulus: 16 reads with matching mem_dat, then op_done.
  - Required: done=1 two cycles after op_done, pass=1, fail_cnt=0, ff_valid=0.
- Single fault:
  - Stimulus: read addr 0x3A expects 0xA, mem_dat=0x8.
  - Required: fail_cnt=1, ff_addr=0x3A, ff_exp=0xA, ff_act=0x8, fail_bits=0x2, pass=0.
- Multiple faults:
  - Stimulus: mismatches at 0x05 (mask 0x1), then 0x10 (mask 0x4).
  - Required: ff_addr stays 0x05, fail_bits=0x5, fail_cnt=2; log pops 0x05/0x1, then 0x10/0x4.
- Log overflow:
  - Stimulus: 6 mismatches with LOG_DEPTH=4 and no pops.
  - Required: log_ovf=1, 4 entries readable, fail_cnt=6.
- Saturation:
  - Stimulus: CNT_W=2 with 5 mismatches.
  - Required: fail_cnt=3.
- Abort and reset:
  - Stimulus 1: en drops mid-RUN. Required: IDLE, done=0.
  - Stimulus 2: rst_n low during DRAIN with READ_LAT=2. Required: all outputs 0 on the next sample.
